// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide unit.
//   - md_op operation codes as driven by Execute (3 bits, code 7 reserved)
//   - FSM state encodings used by md_unit
//   - default busy latencies for the multiply and divide classes
// Optional feature macro used by md_unit: MD_CANCEL_EN (adds the cancel port).
package md_pkg;

    // md_op encodings; code 7 is reserved and behaves like MD_NONE
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Default busy cycles per operation class
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    // True for the ops that occupy the unit for several cycles
    function automatic logic is_multicycle_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational arithmetic core of the multiply/divide unit.
// Ports:
//   op          in  3   md_op code (only MULT/MULTU/DIV/DIVU produce results)
//   a, b        in  32  rs / rt operands
//   res_hi      out 32  product[63:32] or remainder
//   res_lo      out 32  product[31:0]  or quotient
//   div_by_zero out 1   DIV/DIVU with b == 0 (results are then don't-care)
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] b_den;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic        [31:0] b_udiv;
    logic               q_neg;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes; 0x80000000 keeps its bit pattern as
    // an unsigned magnitude, so 0x80000000 / -1 naturally yields 0x80000000.
    assign a_mag  = a[31] ? (~a + 32'd1) : a;
    assign b_mag  = b[31] ? (~b + 32'd1) : b;
    // Divisor forced non-zero so the divider never sees 0; the result is
    // discarded by md_unit whenever div_by_zero is set.
    assign b_den  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_den;
    assign r_mag  = a_mag % b_den;
    assign q_neg  = a[31] ^ b[31];

    assign b_udiv = (b == 32'd0) ? 32'd1 : b;
    assign uq     = a / b_udiv;
    assign ur     = a % b_udiv;

    // Select the result pair for the requested operation; the remainder takes
    // the sign of the dividend, the quotient truncates toward zero.
    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo      = q_neg ? (~q_mag + 32'd1) : q_mag;
                res_hi      = a[31] ? (~r_mag + 32'd1) : r_mag;
                div_by_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                res_lo      = uq;
                res_hi      = ur;
                div_by_zero = (b == 32'd0);
            end
            default: begin
                res_hi      = 32'd0;
                res_lo      = 32'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (Execute stage).
// Ports:
//   clk, rst_n   in   core clock, asynchronous active-low reset
//   start        in   issue strobe, qualified by md_op
//   md_op        in   3-bit operation code (see md_pkg)
//   a, b         in   32-bit rs / rt operands
//   cancel       in   exception flush (only when MD_CANCEL_EN is defined)
//   busy         out  operation in progress
//   start_busy   out  combinational: start with a MULT..DIVU op
//   done         out  one-cycle pulse after HI/LO commit from MULT/DIV
//   hi, lo       out  architectural HI / LO registers
// Parameters: MULT_LAT, DIV_LAT busy cycles per class (both >= 1).
// Optional macro: MD_CANCEL_EN adds the cancel input.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        start_busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             dbz_q,    dbz_d;
    logic [31:0]      hi_q,     hi_d;
    logic [31:0]      lo_q,     lo_d;
    logic             done_q,   done_d;

    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             arith_dbz;
    logic             cancel_w;
    logic             is_mult;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    md_arith u_arith (
        .op          (md_op),
        .a           (a),
        .b           (b),
        .res_hi      (arith_hi),
        .res_lo      (arith_lo),
        .div_by_zero (arith_dbz)
    );

    assign is_mult    = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign start_busy = start & is_multicycle_op(md_op);

    // Next-state logic: results are captured into the shadow registers at the
    // issue edge and only copied to HI/LO at the commit edge, so HI/LO never
    // show a partial update. Starts while RUN are ignored outright.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel_w) begin
                    if (is_multicycle_op(md_op)) begin
                        state_d  = ST_RUN;
                        cnt_d    = is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                        res_hi_d = arith_hi;
                        res_lo_d = arith_lo;
                        dbz_d    = arith_dbz;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                if (cancel_w) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    // Divide by zero still takes the full latency and pulses
                    // done, but leaves HI/LO untouched.
                    if (!dbz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any pending result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dbz_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
